vdisk_sd_sequencer: RTL and testbench

Multi-drive virtual-disk sequencer between the emulated disk controllers and the hps_io SD block-transfer interface. It manages FDD_NUM floppy channels and, optionally, one hard-disk channel. For floppies it streams whole tracks of 512-byte sectors into the track buffer and writes dirty tracks back before a seek. For the hard disk it performs single-sector read and write transfers. It holds `cpu_wait` high while a transfer is in flight. It generalises the single-drive track loader to N drives with write-back.

---
 rtl/vdisk_sd_sequencer_if.sv | 30 +++
 rtl/vdisk_sd_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_vdisk_sd_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdisk_sd_sequencer_if.sv
// SD block-transfer port between the virtual-disk sequencer and hps_io.
// The master drives the per-channel request, LBA and buffer slot; the slave returns sd_ack.
interface vdisk_sd_sequencer_if #(
  parameter int unsigned FDD_NUM = 2
);
  logic [31:0]      sd_lba;
  logic [FDD_NUM:0] sd_rd;
  logic [FDD_NUM:0] sd_wr;
  logic             sd_ack;
  logic [1:0]       buf_drive;
  logic [3:0]       buf_sec;

  modport master (
    output sd_lba,
    output sd_rd,
    output sd_wr,
    output buf_drive,
    output buf_sec,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_rd,
    input  sd_wr,
    input  buf_drive,
    input  buf_sec,
    output sd_ack
  );
endinterface

// File: rtl/vdisk_sd_sequencer.sv
// Multi-drive floppy track loader with write-back plus an optional single-sector HDD channel.
// Define VDISK_HDD_EN to build the hard-disk channel; otherwise HDD inputs are ignored.
module vdisk_sd_sequencer #(
  parameter int unsigned FDD_NUM        = 2,
  parameter int unsigned SECS_PER_TRACK = 13,
  parameter int unsigned TRACK_W        = 6
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [FDD_NUM*TRACK_W-1:0] fdd_track,
  input  logic [FDD_NUM-1:0]         fdd_img_mounted,
  input  logic [FDD_NUM-1:0]         fdd_img_nz,
  input  logic [FDD_NUM-1:0]         fdd_dirty,
  output logic [FDD_NUM-1:0]         fdd_dirty_clr,
  input  logic [15:0]                hdd_sector,
  input  logic                       hdd_read,
  input  logic                       hdd_write,
  input  logic                       hdd_img_mounted,
  input  logic                       hdd_img_nz,
  input  logic                       hdd_img_ro,
  output logic                       hdd_mounted,
  output logic                       hdd_protect,
  output logic                       cpu_wait,
  vdisk_sd_sequencer_if.master       sd
);

  localparam int unsigned      DrvW    = (FDD_NUM > 1) ? $clog2(FDD_NUM) : 1;
  localparam logic [3:0]       SecLast = 4'(SECS_PER_TRACK - 1);
  localparam logic [FDD_NUM:0] HddOh   = {1'b1, {FDD_NUM{1'b0}}};

  typedef logic [TRACK_W-1:0] track_t;

  typedef enum logic [1:0] {
    StIdle,
    StFddWb,
    StFddLd,
    StHddXf
  } state_e;

  function automatic logic [31:0] track_lba(input track_t t);
    return 32'(SECS_PER_TRACK) * 32'(t);
  endfunction

  function automatic logic [FDD_NUM:0] chan_oh(input int unsigned c);
    return (FDD_NUM + 1)'(1) << c;
  endfunction

  state_e                state_q, state_d;
  logic [DrvW-1:0]       drv_q, drv_d;
  logic                  hdd_wr_op_q, hdd_wr_op_d;
  logic [31:0]           lba_q, lba_d;
  logic [FDD_NUM:0]      rd_q, rd_d;
  logic [FDD_NUM:0]      wr_q, wr_d;
  logic [3:0]            sec_q, sec_d;
  logic                  wait_q, wait_d;
  logic [FDD_NUM-1:0]    clr_q, clr_d;
  logic                  ack_q;
  track_t                cur_track_q [FDD_NUM];
  track_t                cur_track_d [FDD_NUM];
  logic [FDD_NUM-1:0]    loaded_q, loaded_d;
  logic [FDD_NUM-1:0]    remount_q, remount_d;
  logic [FDD_NUM-1:0]    nz_q, nz_d;
  logic [FDD_NUM-1:0]    need;
  logic                  found;
  logic                  pend_rd_q, pend_wr_q;
  logic                  pend_rd_clr, pend_wr_clr;
  logic                  hdd_mounted_q, hdd_protect_q;

  logic ack_rise, ack_fall, ack_quiet;
  assign ack_rise  = sd.sd_ack & ~ack_q;
  assign ack_fall  = ~sd.sd_ack & ack_q;
  // A new service never starts while the previous ack handshake is still winding down.
  assign ack_quiet = ~sd.sd_ack & ~ack_q;

  always_comb begin
    need = '0;
    for (int d = 0; d < FDD_NUM; d++) begin
      need[d] = (remount_q[d] & ~fdd_img_mounted[d]) |
                (loaded_q[d] & (fdd_track[d*TRACK_W +: TRACK_W] != cur_track_q[d]));
    end
  end

  always_comb begin
    state_d     = state_q;
    drv_d       = drv_q;
    hdd_wr_op_d = hdd_wr_op_q;
    lba_d       = lba_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    sec_d       = sec_q;
    wait_d      = wait_q;
    clr_d       = '0;
    cur_track_d = cur_track_q;
    loaded_d    = loaded_q;
    remount_d   = remount_q;
    nz_d        = nz_q;
    pend_rd_clr = 1'b0;
    pend_wr_clr = 1'b0;
    found       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ack_quiet) begin
          if (pend_rd_q) begin
            state_d     = StHddXf;
            hdd_wr_op_d = 1'b0;
            lba_d       = {16'h0, hdd_sector};
            rd_d        = HddOh;
            wait_d      = 1'b1;
          end else if (pend_wr_q) begin
            state_d     = StHddXf;
            hdd_wr_op_d = 1'b1;
            lba_d       = {16'h0, hdd_sector};
            wr_d        = HddOh;
            wait_d      = 1'b1;
          end else begin
            for (int d = 0; d < FDD_NUM; d++) begin
              if (need[d] && !found) begin
                found          = 1'b1;
                drv_d          = DrvW'(d);
                sec_d          = '0;
                cur_track_d[d] = fdd_track[d*TRACK_W +: TRACK_W];
                if (!nz_q[d]) begin
                  loaded_d[d]  = 1'b0;
                  remount_d[d] = 1'b0;
                end else if (fdd_dirty[d] && !remount_q[d]) begin
                  // Write back the track the buffer still holds, not the new head position.
                  state_d = StFddWb;
                  lba_d   = track_lba(cur_track_q[d]);
                  wr_d    = chan_oh(d);
                  wait_d  = 1'b1;
                end else begin
                  state_d = StFddLd;
                  lba_d   = track_lba(fdd_track[d*TRACK_W +: TRACK_W]);
                  rd_d    = chan_oh(d);
                  wait_d  = 1'b1;
                end
              end
            end
          end
        end
      end

      StFddWb, StFddLd: begin
        if (ack_rise) begin
          lba_d = lba_q + 32'd1;
          if (sec_q == SecLast) begin
            rd_d = '0;
            wr_d = '0;
          end
        end else if (ack_fall) begin
          if ((rd_q | wr_q) != '0) begin
            sec_d = sec_q + 4'd1;
          end else if (state_q == StFddWb) begin
            clr_d   = FDD_NUM'(1) << drv_q;
            state_d = StFddLd;
            lba_d   = track_lba(cur_track_q[drv_q]);
            sec_d   = '0;
            rd_d    = chan_oh(32'(drv_q));
          end else begin
            loaded_d[drv_q]  = 1'b1;
            remount_d[drv_q] = 1'b0;
            state_d          = StIdle;
            wait_d           = 1'b0;
          end
        end
      end

      StHddXf: begin
        if (ack_rise) begin
          rd_d    = '0;
          wr_d    = '0;
          state_d = StIdle;
          wait_d  = 1'b0;
          if (hdd_wr_op_q) begin
            pend_wr_clr = 1'b1;
          end else begin
            pend_rd_clr = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A fresh mount pulse wins over any clear made by a completing service.
    for (int d = 0; d < FDD_NUM; d++) begin
      if (fdd_img_mounted[d]) begin
        remount_d[d] = 1'b1;
        nz_d[d]      = fdd_img_nz[d];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      drv_q       <= '0;
      hdd_wr_op_q <= 1'b0;
      lba_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      sec_q       <= '0;
      wait_q      <= 1'b0;
      clr_q       <= '0;
      ack_q       <= 1'b0;
      loaded_q    <= '0;
      remount_q   <= '0;
      nz_q        <= '0;
      for (int d = 0; d < FDD_NUM; d++) begin
        cur_track_q[d] <= '0;
      end
    end else begin
      state_q     <= state_d;
      drv_q       <= drv_d;
      hdd_wr_op_q <= hdd_wr_op_d;
      lba_q       <= lba_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      sec_q       <= sec_d;
      wait_q      <= wait_d;
      clr_q       <= clr_d;
      ack_q       <= sd.sd_ack;
      loaded_q    <= loaded_d;
      remount_q   <= remount_d;
      nz_q        <= nz_d;
      cur_track_q <= cur_track_d;
    end
  end

`ifdef VDISK_HDD_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_rd_q     <= 1'b0;
      pend_wr_q     <= 1'b0;
      hdd_mounted_q <= 1'b0;
      hdd_protect_q <= 1'b0;
    end else begin
      pend_rd_q <= (pend_rd_q & ~pend_rd_clr) | hdd_read;
      pend_wr_q <= (pend_wr_q & ~pend_wr_clr) | hdd_write;
      if (hdd_img_mounted) begin
        hdd_mounted_q <= hdd_img_nz;
        hdd_protect_q <= hdd_img_ro;
      end
    end
  end
`else
  assign pend_rd_q     = 1'b0;
  assign pend_wr_q     = 1'b0;
  assign hdd_mounted_q = 1'b0;
  assign hdd_protect_q = 1'b0;

  logic unused_hdd;
  assign unused_hdd = ^{hdd_read, hdd_write, hdd_img_mounted, hdd_img_nz, hdd_img_ro,
                        pend_rd_clr, pend_wr_clr};
`endif

  assign sd.sd_lba     = lba_q;
  assign sd.sd_rd      = rd_q;
  assign sd.sd_wr      = wr_q;
  assign sd.buf_sec    = sec_q;
  assign sd.buf_drive  = 2'(drv_q);
  assign cpu_wait      = wait_q;
  assign fdd_dirty_clr = clr_q;
  assign hdd_mounted   = hdd_mounted_q;
  assign hdd_protect   = hdd_protect_q;

endmodule

// File: tb/tb_vdisk_sd_sequencer.sv
// Scoreboard bench: stimulus pushes expected SD transfers, a monitor pops them on each ack rise.
module tb_vdisk_sd_sequencer;
  localparam int unsigned FdN = 2;
  localparam int unsigned Spt = 13;
  localparam int unsigned Tw  = 6;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [FdN*Tw-1:0] fdd_track;
  logic [FdN-1:0]    fdd_img_mounted, fdd_img_nz, fdd_dirty, fdd_dirty_clr;
  logic [15:0]       hdd_sector;
  logic              hdd_read, hdd_write, hdd_img_mounted, hdd_img_nz, hdd_img_ro;
  logic              hdd_mounted, hdd_protect, cpu_wait;

  always #5 clk_sys = ~clk_sys;

  vdisk_sd_sequencer_if #(.FDD_NUM(FdN)) sif ();

  vdisk_sd_sequencer #(
    .FDD_NUM       (FdN),
    .SECS_PER_TRACK(Spt),
    .TRACK_W       (Tw)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .fdd_track      (fdd_track),
    .fdd_img_mounted(fdd_img_mounted),
    .fdd_img_nz     (fdd_img_nz),
    .fdd_dirty      (fdd_dirty),
    .fdd_dirty_clr  (fdd_dirty_clr),
    .hdd_sector     (hdd_sector),
    .hdd_read       (hdd_read),
    .hdd_write      (hdd_write),
    .hdd_img_mounted(hdd_img_mounted),
    .hdd_img_nz     (hdd_img_nz),
    .hdd_img_ro     (hdd_img_ro),
    .hdd_mounted    (hdd_mounted),
    .hdd_protect    (hdd_protect),
    .cpu_wait       (cpu_wait),
    .sd             (sif)
  );

  typedef struct packed {
    logic [FdN:0]   rd;
    logic [FdN:0]   wr;
    logic [FdN-1:0] clr;
    logic [31:0]    lba;
    logic [3:0]     sec;
    logic [1:0]     drv;
    logic           chk_buf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rise_cnt = 0;
  int   cw_rises = 0;
  bit   ack_en   = 1'b1;
  logic mon_prev_ack = 1'b0;
  logic mon_prev_cw  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic set_track(input int d, input int t);
    fdd_track[d*Tw +: Tw] = Tw'(t);
  endtask

  task automatic mount(input int d, input bit nz);
    tick(1);
    fdd_img_nz[d]      = nz;
    fdd_img_mounted[d] = 1'b1;
    tick(1);
    fdd_img_mounted[d] = 1'b0;
  endtask

  task automatic push_xfer(input bit wr, input int ch, input int lba0, input int n, input int drv,
                           input bit chk);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e         = '0;
      e.rd      = wr ? '0 : (FdN + 1)'(1) << ch;
      e.wr      = wr ? (FdN + 1)'(1) << ch : '0;
      e.lba     = 32'(lba0 + i);
      e.sec     = 4'(i);
      e.drv     = 2'(drv);
      e.chk_buf = chk;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_clr(input logic [FdN-1:0] mask);
    exp_t e;
    e     = '0;
    e.clr = mask;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && !cpu_wait && sif.sd_rd == '0 &&
                           sif.sd_wr == '0 && !sif.sd_ack)) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s timeout pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic wait_rise(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && rise_cnt < target) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s timeout acks=%0d required=%0d", name, rise_cnt, target);
    end
  endtask

  // hps_io model: acknowledge any pending request with a 2-cycle ack pulse.
  initial begin
    sif.sd_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (ack_en && reset_n && ((sif.sd_rd | sif.sd_wr) != '0)) begin
        @(posedge clk_sys);
        #1 sif.sd_ack = 1'b1;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1 sif.sd_ack = 1'b0;
        @(posedge clk_sys);
      end
    end
  end

  // Monitor: pops the scoreboard on every ack rise and every dirty-clear pulse.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        mon_prev_ack = sif.sd_ack;
        mon_prev_cw  = 1'b0;
      end else begin
        if (cpu_wait && !mon_prev_cw) cw_rises++;
        mon_prev_cw = cpu_wait;
        if ((sif.sd_rd | sif.sd_wr) != '0) check("wait_during_req", 32'(cpu_wait), 32'd1);
        if (fdd_dirty_clr != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_clr actual=%0h required=none", fdd_dirty_clr);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dirty_clr", 32'(fdd_dirty_clr), 32'(e.clr));
          end
        end
        if (sif.sd_ack && !mon_prev_ack) begin
          rise_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_xfer actual lba=%0h rd=%0h wr=%0h required=none",
                     sif.sd_lba, sif.sd_rd, sif.sd_wr);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("xfer_rd", 32'(sif.sd_rd), 32'(e.rd));
            check("xfer_wr", 32'(sif.sd_wr), 32'(e.wr));
            check("xfer_lba", sif.sd_lba, e.lba);
            check("xfer_wait", 32'(cpu_wait), 32'd1);
            if (e.chk_buf) begin
              check("xfer_buf_sec", 32'(sif.buf_sec), 32'(e.sec));
              check("xfer_buf_drive", 32'(sif.buf_drive), 32'(e.drv));
            end
          end
        end
        mon_prev_ack = sif.sd_ack;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cw0;
    int r0;
    fdd_track       = '0;
    fdd_img_mounted = '0;
    fdd_img_nz      = '0;
    fdd_dirty       = '0;
    hdd_sector      = '0;
    hdd_read        = 1'b0;
    hdd_write       = 1'b0;
    hdd_img_mounted = 1'b0;
    hdd_img_nz      = 1'b0;
    hdd_img_ro      = 1'b0;
    reset_n         = 1'b0;
    tick(3);

    check("rst_sd_rd", 32'(sif.sd_rd), 32'd0);
    check("rst_sd_wr", 32'(sif.sd_wr), 32'd0);
    check("rst_sd_lba", sif.sd_lba, 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_buf_sec", 32'(sif.buf_sec), 32'd0);
    check("rst_buf_drive", 32'(sif.buf_drive), 32'd0);
    check("rst_dirty_clr", 32'(fdd_dirty_clr), 32'd0);
    check("rst_hdd_mounted", 32'(hdd_mounted), 32'd0);
    check("rst_hdd_protect", 32'(hdd_protect), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Fresh mount of drive 0 at track 5: LBAs 65..77.
    cw0 = cw_rises;
    set_track(0, 5);
    push_xfer(1'b0, 0, 65, 13, 0, 1'b1);
    mount(0, 1'b1);
    wait_done("t1_load", 2000);
    check("t1_wait_rises", 32'(cw_rises - cw0), 32'd1);

    // Dirty step 5 -> 6: write back 65..77, clear pulse, load 78..90, one continuous wait.
    cw0 = cw_rises;
    fdd_dirty[0] = 1'b1;
    push_xfer(1'b1, 0, 65, 13, 0, 1'b1);
    push_clr(2'b01);
    push_xfer(1'b0, 0, 78, 13, 0, 1'b1);
    set_track(0, 6);
    wait_done("t2_wb_ld", 4000);
    fdd_dirty[0] = 1'b0;
    check("t2_wait_continuous", 32'(cw_rises - cw0), 32'd1);

    // Zero-size remount: no traffic now, none after a track change either.
    cw0 = cw_rises;
    mount(0, 1'b0);
    tick(30);
    set_track(0, 7);
    tick(30);
    check("t3_no_wait", 32'(cw_rises - cw0), 32'd0);
    check("t3_idle_rd", 32'(sif.sd_rd), 32'd0);
    check("t3_idle_wait", 32'(cpu_wait), 32'd0);

`ifdef VDISK_HDD_EN
    tick(1);
    hdd_img_nz      = 1'b1;
    hdd_img_ro      = 1'b1;
    hdd_img_mounted = 1'b1;
    tick(1);
    hdd_img_mounted = 1'b0;
    tick(1);
    check("t4_hdd_mounted", 32'(hdd_mounted), 32'd1);
    check("t4_hdd_protect", 32'(hdd_protect), 32'd1);

    // Drive 1 load at track 2 (LBA 26..), HDD read+write pulsed together mid-load.
    set_track(1, 2);
    push_xfer(1'b0, 1, 26, 13, 1, 1'b1);
    r0 = rise_cnt;
    mount(1, 1'b1);
    wait_rise("t4_first_ack", r0 + 1, 500);
    hdd_sector = 16'h1234;
    push_xfer(1'b0, 2, 32'h1234, 1, 0, 1'b0);
    push_xfer(1'b1, 2, 32'h1234, 1, 0, 1'b0);
    hdd_read  = 1'b1;
    hdd_write = 1'b1;
    tick(1);
    hdd_read  = 1'b0;
    hdd_write = 1'b0;
    wait_done("t4_hdd", 4000);
`else
    cw0 = cw_rises;
    tick(1);
    hdd_img_nz      = 1'b1;
    hdd_img_ro      = 1'b1;
    hdd_img_mounted = 1'b1;
    tick(1);
    hdd_img_mounted = 1'b0;
    hdd_sector      = 16'h1234;
    hdd_read        = 1'b1;
    tick(1);
    hdd_read        = 1'b0;
    tick(40);
    check("t4_hdd_mounted_off", 32'(hdd_mounted), 32'd0);
    check("t4_hdd_protect_off", 32'(hdd_protect), 32'd0);
    check("t4_hdd_no_wait", 32'(cw_rises - cw0), 32'd0);
`endif

    // Reset after the 4th ack of a track-7 load (LBA 91..), then a full reload on remount.
    push_xfer(1'b0, 0, 91, 4, 0, 1'b1);
    r0 = rise_cnt;
    mount(0, 1'b1);
    wait_rise("t5_four_acks", r0 + 4, 1000);
    ack_en = 1'b0;
    r0 = 0;
    while (sif.sd_ack && r0 < 50) begin
      tick(1);
      r0++;
    end
    tick(2);
    check("t5_req_before_rst", 32'(sif.sd_rd), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_sd_rd", 32'(sif.sd_rd), 32'd0);
    check("t5_rst_wait", 32'(cpu_wait), 32'd0);
    check("t5_consumed", 32'(exp_q.size()), 32'd0);
    tick(2);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    tick(2);
    push_xfer(1'b0, 0, 91, 13, 0, 1'b1);
    mount(0, 1'b1);
    wait_done("t5_reload", 2000);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
